// File: rtl/buscador_igualdade_if.sv
// Bus between a requester and the exhaustive equality/difference search block.
// The requester drives the request fields; the search block drives the results.
interface buscador_igualdade_if #(
    parameter int N = 3
);
    logic         start;
    logic         abort;
    logic [N-1:0] a;
    logic         select;
    logic [N-1:0] b_out;
    logic         busy;
    logic         done;
    logic         found;
    logic [N-1:0] first_idx;
    logic [N:0]   match_count;

    modport master (
        output start, abort, a, select,
        input  b_out, busy, done, found, first_idx, match_count
    );

    modport slave (
        input  start, abort, a, select,
        output b_out, busy, done, found, first_idx, match_count
    );
endinterface

// File: rtl/buscador_igualdade.sv
// Sweeps every N-bit candidate against a latched target and reports whether any
// matched, the lowest matching candidate and how many matched.
module buscador_igualdade #(
    parameter int N = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    buscador_igualdade_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        FIM   = 2'd2
    } state_t;

    state_t       state_reg, state_next;
    logic [N-1:0] b_reg;
    logic [N-1:0] a_lat_reg;
    logic         select_lat_reg;
    logic         found_acc_reg, found_acc_next;
    logic [N-1:0] first_acc_reg, first_acc_next;
    logic [N:0]   count_acc_reg, count_acc_next;
    logic         found_reg;
    logic [N-1:0] first_idx_reg;
    logic [N:0]   count_reg;
    logic         busy_reg, done_reg;
    logic         equal, match, last;

    assign equal = &(b_reg ~^ a_lat_reg);
    assign match = equal ^ select_lat_reg;
    assign last  = (b_reg == {N{1'b1}});

    always_comb begin
        state_next     = state_reg;
        found_acc_next = found_acc_reg;
        first_acc_next = first_acc_reg;
        count_acc_next = count_acc_reg;
        case (state_reg)
            IDLE: begin
                if (bus.start) state_next = SWEEP;
            end
            SWEEP: begin
                if (bus.abort)  state_next = IDLE;
                else if (last)  state_next = FIM;
                if (match) begin
                    found_acc_next = 1'b1;
                    if (!found_acc_reg) first_acc_next = b_reg;
                    count_acc_next = count_acc_reg + {{N{1'b0}}, 1'b1};
                end
            end
            FIM:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // busy/done are registered copies of the next state so they never glitch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            busy_reg  <= (state_next == SWEEP);
            done_reg  <= (state_next == FIM);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_reg          <= '0;
            a_lat_reg      <= '0;
            select_lat_reg <= 1'b0;
            found_acc_reg  <= 1'b0;
            first_acc_reg  <= '0;
            count_acc_reg  <= '0;
            found_reg      <= 1'b0;
            first_idx_reg  <= '0;
            count_reg      <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.start) begin
                        a_lat_reg      <= bus.a;
                        select_lat_reg <= bus.select;
                        found_acc_reg  <= 1'b0;
                        first_acc_reg  <= '0;
                        count_acc_reg  <= '0;
                        b_reg          <= '0;
                    end
                end
                SWEEP: begin
                    if (bus.abort) begin
                        b_reg <= '0;
                    end else begin
                        found_acc_reg <= found_acc_next;
                        first_acc_reg <= first_acc_next;
                        count_acc_reg <= count_acc_next;
                        // Incrementing past the all-ones candidate wraps to 0.
                        b_reg         <= b_reg + {{(N-1){1'b0}}, 1'b1};
                        if (last) begin
                            // Results land together with done, including the last candidate.
                            found_reg     <= found_acc_next;
                            first_idx_reg <= first_acc_next;
                            count_reg     <= count_acc_next;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.b_out       = b_reg;
    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.found       = found_reg;
    assign bus.first_idx   = first_idx_reg;
    assign bus.match_count = count_reg;
endmodule

// File: tb/tb_buscador_igualdade.sv
// Self-checking bench for buscador_igualdade: directed scenarios plus random
// sweeps compared against a candidate-by-candidate reference model.
module tb_buscador_igualdade;
    localparam int N = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    buscador_igualdade_if #(.N(N)) bus ();

    buscador_igualdade #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int checks = 0;
    int passed = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void ref_model(input logic [N-1:0] av, input logic sv,
                                      output logic f, output logic [N-1:0] fi,
                                      output logic [N:0] cnt);
        f = 1'b0; fi = '0; cnt = '0;
        for (int c = 0; c < (1 << N); c++) begin
            bit m;
            m = sv ? (c != int'(av)) : (c == int'(av));
            if (m) begin
                if (!f) fi = c[N-1:0];
                f = 1'b1;
                cnt = cnt + 1'b1;
            end
        end
    endfunction

    task automatic run_sweep(input logic [N-1:0] av, input logic sv,
                             output int busy_n, output bit done_seen);
        bus.a = av; bus.select = sv; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        busy_n = 0; done_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin done_seen = 1'b1; break; end
            if (bus.busy) busy_n++;
            step();
        end
    endtask

    task automatic test_reset();
        step();
        checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy actual=%0b required=0", bus.busy); else passed++;
        checks++; if (bus.done !== 1'b0) $display("FAIL rst_done actual=%0b required=0", bus.done); else passed++;
        checks++; if (bus.b_out !== 3'd0) $display("FAIL rst_b_out actual=%0d required=0", bus.b_out); else passed++;
        checks++; if ({bus.found, bus.first_idx, bus.match_count} !== 8'd0)
            $display("FAIL rst_results actual=%0b/%0d/%0d required=0/0/0", bus.found, bus.first_idx, bus.match_count); else passed++;
        rst_n = 1'b1;
        step(); step();
        checks++; if (bus.busy !== 1'b0) $display("FAIL rst_idle_busy actual=%0b required=0", bus.busy); else passed++;
    endtask

    task automatic test_equality();
        logic f; logic [N-1:0] fi; logic [N:0] cnt;
        ref_model(3'b101, 1'b0, f, fi, cnt);
        bus.a = 3'b101; bus.select = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.busy !== 1'b1 || bus.done !== 1'b0)
                $display("FAIL eq_busy cycle=%0d actual=%0b/%0b required=1/0", i, bus.busy, bus.done); else passed++;
            checks++; if (bus.b_out !== 3'(i))
                $display("FAIL eq_b_out cycle=%0d actual=%0d required=%0d", i, bus.b_out, i); else passed++;
            step();
        end
        checks++; if (bus.done !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL eq_done actual=%0b/%0b required=1/0", bus.done, bus.busy); else passed++;
        checks++; if (bus.b_out !== 3'd0) $display("FAIL eq_wrap actual=%0d required=0", bus.b_out); else passed++;
        checks++; if (bus.found !== f || bus.first_idx !== fi || bus.match_count !== cnt)
            $display("FAIL eq_result actual=%0b/%0d/%0d required=%0b/%0d/%0d",
                     bus.found, bus.first_idx, bus.match_count, f, fi, cnt); else passed++;
        step();
        checks++; if (bus.done !== 1'b0) $display("FAIL eq_done_pulse actual=%0b required=0", bus.done); else passed++;
        checks++; if (bus.found !== f || bus.first_idx !== fi || bus.match_count !== cnt)
            $display("FAIL eq_hold actual=%0b/%0d/%0d required=%0b/%0d/%0d",
                     bus.found, bus.first_idx, bus.match_count, f, fi, cnt); else passed++;
    endtask

    task automatic test_difference();
        int bn; bit ds;
        logic f; logic [N-1:0] fi; logic [N:0] cnt;
        ref_model(3'b000, 1'b1, f, fi, cnt);
        run_sweep(3'b000, 1'b1, bn, ds);
        checks++; if (!ds || bn != 8) $display("FAIL diff_timing actual=done:%0b busy:%0d required=done:1 busy:8", ds, bn); else passed++;
        checks++; if (bus.found !== f || bus.first_idx !== fi || bus.match_count !== cnt)
            $display("FAIL diff_result actual=%0b/%0d/%0d required=%0b/%0d/%0d",
                     bus.found, bus.first_idx, bus.match_count, f, fi, cnt); else passed++;
        step();
    endtask

    task automatic test_change_mid();
        bit ds = 1'b0;
        logic f; logic [N-1:0] fi; logic [N:0] cnt;
        ref_model(3'b010, 1'b0, f, fi, cnt);
        bus.a = 3'b010; bus.select = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step(); step(); step();
        bus.a = 3'b101; bus.select = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (bus.done) begin ds = 1'b1; break; end
            step();
        end
        checks++; if (!ds) $display("FAIL mid_done actual=0 required=1"); else passed++;
        checks++; if (bus.found !== f || bus.first_idx !== fi || bus.match_count !== cnt)
            $display("FAIL mid_result actual=%0b/%0d/%0d required=%0b/%0d/%0d",
                     bus.found, bus.first_idx, bus.match_count, f, fi, cnt); else passed++;
        bus.select = 1'b0;
        step();
    endtask

    task automatic test_abort();
        int bn; bit ds; int dn;
        logic f; logic [N-1:0] fi; logic [N:0] cnt;
        ref_model(3'b101, 1'b0, f, fi, cnt);
        run_sweep(3'b101, 1'b0, bn, ds);
        step();
        // abort in the 4th sweep cycle
        bus.a = 3'b111; bus.select = 1'b0; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step(); step(); step();
        checks++; if (bus.b_out !== 3'd3) $display("FAIL abort_pos actual=%0d required=3", bus.b_out); else passed++;
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.b_out !== 3'd0)
            $display("FAIL abort_idle actual=%0b/%0b/%0d required=0/0/0", bus.busy, bus.done, bus.b_out); else passed++;
        dn = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.done || bus.busy) dn++;
            step();
        end
        checks++; if (dn != 0) $display("FAIL abort_quiet actual=%0d required=0", dn); else passed++;
        checks++; if (bus.found !== f || bus.first_idx !== fi || bus.match_count !== cnt)
            $display("FAIL abort_keep actual=%0b/%0d/%0d required=%0b/%0d/%0d",
                     bus.found, bus.first_idx, bus.match_count, f, fi, cnt); else passed++;
        // abort coinciding with the last candidate
        bus.a = 3'b000; bus.select = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < 7; i++) step();
        checks++; if (bus.b_out !== 3'd7) $display("FAIL abort_last_pos actual=%0d required=7", bus.b_out); else passed++;
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        dn = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.done || bus.busy) dn++;
            step();
        end
        checks++; if (dn != 0) $display("FAIL abort_last_quiet actual=%0d required=0", dn); else passed++;
        checks++; if (bus.found !== f || bus.first_idx !== fi || bus.match_count !== cnt)
            $display("FAIL abort_last_keep actual=%0b/%0d/%0d required=%0b/%0d/%0d",
                     bus.found, bus.first_idx, bus.match_count, f, fi, cnt); else passed++;
    endtask

    task automatic test_async_reset();
        int bn; bit ds;
        logic f; logic [N-1:0] fi; logic [N:0] cnt;
        bus.a = 3'b110; bus.select = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.b_out !== 3'd0)
            $display("FAIL areset_ctrl actual=%0b/%0b/%0d required=0/0/0", bus.busy, bus.done, bus.b_out); else passed++;
        checks++; if (bus.found !== 1'b0 || bus.first_idx !== 3'd0 || bus.match_count !== 4'd0)
            $display("FAIL areset_results actual=%0b/%0d/%0d required=0/0/0", bus.found, bus.first_idx, bus.match_count); else passed++;
        step();
        rst_n = 1'b1;
        step(); step();
        checks++; if (bus.busy !== 1'b0) $display("FAIL areset_idle actual=%0b required=0", bus.busy); else passed++;
        ref_model(3'b011, 1'b0, f, fi, cnt);
        run_sweep(3'b011, 1'b0, bn, ds);
        checks++; if (!ds || bn != 8) $display("FAIL areset_sweep actual=done:%0b busy:%0d required=done:1 busy:8", ds, bn); else passed++;
        checks++; if (bus.found !== f || bus.first_idx !== fi || bus.match_count !== cnt)
            $display("FAIL areset_result actual=%0b/%0d/%0d required=%0b/%0d/%0d",
                     bus.found, bus.first_idx, bus.match_count, f, fi, cnt); else passed++;
        step();
    endtask

    task automatic test_back_to_back();
        int dones = 0, busies = 0;
        logic f; logic [N-1:0] fi; logic [N:0] cnt;
        bus.a = 3'b011; bus.select = 1'b0; bus.start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.busy) busies++;
            if (bus.done) begin
                dones++;
                ref_model(3'b011, dones > 1, f, fi, cnt);
                checks++; if (bus.found !== f || bus.first_idx !== fi || bus.match_count !== cnt)
                    $display("FAIL b2b_result sweep=%0d actual=%0b/%0d/%0d required=%0b/%0d/%0d",
                             dones, bus.found, bus.first_idx, bus.match_count, f, fi, cnt); else passed++;
                bus.select = 1'b1;
            end
        end
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (bus.busy) busies++;
            if (bus.done) dones++;
        end
        checks++; if (dones != 2) $display("FAIL b2b_dones actual=%0d required=2", dones); else passed++;
        checks++; if (busies != 16) $display("FAIL b2b_busy actual=%0d required=16", busies); else passed++;
        bus.select = 1'b0;
    endtask

    task automatic test_random();
        int bn; bit ds;
        logic f; logic [N-1:0] fi; logic [N:0] cnt;
        logic [N-1:0] av; logic sv;
        for (int t = 0; t < 8; t++) begin
            av = N'($urandom_range(0, 7));
            sv = 1'($urandom_range(0, 1));
            ref_model(av, sv, f, fi, cnt);
            run_sweep(av, sv, bn, ds);
            checks++; if (!ds || bn != 8)
                $display("FAIL rnd_timing a=%0d sel=%0b actual=done:%0b busy:%0d required=done:1 busy:8", av, sv, ds, bn); else passed++;
            checks++; if (bus.found !== f || bus.first_idx !== fi || bus.match_count !== cnt)
                $display("FAIL rnd_result a=%0d sel=%0b actual=%0b/%0d/%0d required=%0b/%0d/%0d",
                         av, sv, bus.found, bus.first_idx, bus.match_count, f, fi, cnt); else passed++;
            step();
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.abort = 1'b0; bus.a = '0; bus.select = 1'b0;
        test_reset();
        test_equality();
        test_difference();
        test_change_mid();
        test_abort();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
